// File: rtl/vektor_pkg.sv
// Shared constants and state encoding for the vector sequencer and the
// kryssprodukt block it feeds.
package vektor_pkg;

    localparam int BYTE_W                = 8;
    localparam int VEC_LEN               = 4;
    localparam int VEC_W                 = BYTE_W * VEC_LEN;
    localparam int DEFAULT_SETTLE_CYCLES = 2;

    localparam int LOAD_CNT_W   = $clog2(2 * VEC_LEN);
    localparam int IDX_W        = $clog2(VEC_LEN);
    localparam int SETTLE_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

endpackage

// File: rtl/vektor_sekvenser.sv
// Loads a and b operand vectors byte by byte, waits for kryssprodukt to settle,
// captures its c vector and streams the result out one byte at a time.
module vektor_sekvenser
    import vektor_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [VEC_W-1:0]  a_vec,
    output logic [VEC_W-1:0]  b_vec,
    input  logic [VEC_W-1:0]  c_vec,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [LOAD_CNT_W-1:0]   LOAD_LAST   = LOAD_CNT_W'(2 * VEC_LEN - 1);
    localparam logic [IDX_W-1:0]        IDX_LAST    = IDX_W'(VEC_LEN - 1);
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [LOAD_CNT_W-1:0]   load_idx;
    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic [IDX_W-1:0]        idx;
    logic [VEC_W-1:0]        result;
    logic                    in_xfer;
    logic                    out_xfer;
    logic                    settle_last;

    // Handshake flags are pure state decodes so in_ready never depends on in_valid.
    assign in_ready    = (state == ST_LOAD);
    assign out_valid   = (state == ST_SEND);
    assign busy        = (state != ST_LOAD);
    assign in_xfer     = in_valid && in_ready;
    assign out_xfer    = out_valid && out_ready;
    assign settle_last = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);
    assign out_data    = result[{idx, 3'b000} +: BYTE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                if (in_xfer && (load_idx == LOAD_LAST)) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_last) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_xfer && (idx == IDX_LAST)) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    // Top bit of load_idx picks a versus b; the counter wraps to 0 after b4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_idx <= '0;
            a_vec    <= '0;
            b_vec    <= '0;
        end else if (in_xfer) begin
            load_idx <= load_idx + LOAD_CNT_W'(1);
            if (!load_idx[IDX_W]) begin
                a_vec[{load_idx[IDX_W-1:0], 3'b000} +: BYTE_W] <= in_data;
            end else begin
                b_vec[{load_idx[IDX_W-1:0], 3'b000} +: BYTE_W] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            result     <= '0;
        end else if (state == ST_SETTLE) begin
            if (settle_last) begin
                settle_cnt <= '0;
                result     <= c_vec;
            end else begin
                settle_cnt <= settle_cnt + SETTLE_CNT_W'(1);
            end
        end
    end

    // idx wraps from 3 back to 0 on the final output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (out_xfer) begin
            idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: doc/vektor_sekvenser.md
VEKTOR_SEKVENSER -- requirements
Module: vektor_sekvenser

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: number of cycles the vector outputs are held stable before the result is captured; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 in_data  input  8  operand byte stream.
REQ-005 in_valid  input  1  in_data holds a valid byte.
REQ-006 in_ready  output  1  block accepts a byte this cycle.
REQ-007 a_vec  output  32  {a4,a3,a2,a1}; drives kryssprodukt a-ports.
REQ-008 b_vec  output  32  {b4,b3,b2,b1}; drives kryssprodukt b-ports.
REQ-009 c_vec  input  32  {c4,c3,c2,c1}; driven by kryssprodukt c-ports.
REQ-010 out_data  output  8  result byte stream.
REQ-011 out_valid  output  1  out_data holds a valid byte.
REQ-012 out_ready  input  1  consumer accepts out_data this cycle.
REQ-013 busy  output  1  high in every state except LOAD.

Function
REQ-014 The FSM SHALL have the states LOAD, SETTLE and SEND.
REQ-015 A byte transfer SHALL occur on a rising edge where in_valid and in_ready are both high.
REQ-016 in_ready SHALL be high only in LOAD; it SHALL be a decode of the state register and SHALL NOT depend on in_valid.
REQ-017 In LOAD, transfers 0..3 SHALL write a1..a4 and transfers 4..7 SHALL write b1..b4, in that order.
REQ-018 On transfer 7, the next state SHALL be SETTLE and the load index SHALL wrap to 0.
REQ-019 a_vec and b_vec SHALL be registered, and SHALL change only on a LOAD transfer or on reset.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles; on its last cycle, c_vec SHALL be captured into a 32-bit result register and the state SHALL go to SEND.
REQ-021 In SEND, out_valid SHALL be 1 and out_data SHALL be result byte idx, where idx 0..3 selects c1..c4.
REQ-022 idx SHALL advance only when out_valid and out_ready are both high.
REQ-023 While out_ready is low, out_data and idx SHALL hold.
REQ-024 After the transfer at idx 3, the state SHALL return to LOAD with idx at 0 and out_valid at 0 on the next cycle.
REQ-025 Latency from the last input transfer to the first out_valid SHALL be SETTLE_CYCLES+1 cycles.
REQ-026 in_valid in a non-LOAD state SHALL be ignored, with no write and no error.
REQ-027 out_valid and in_ready SHALL never be high in the same cycle.
REQ-028 All arithmetic SHALL be done inside kryssprodukt; this block SHALL perform no width changes beyond byte slicing.

Reset
REQ-029 When rst_n is asserted (low), the state SHALL be LOAD and the load index, settle count and idx SHALL be 0.
REQ-030 While rst_n is asserted (low), a_vec, b_vec, the result register and out_data SHALL be 0, and out_valid and busy SHALL be 0.
REQ-031 in_ready SHALL be 1 on the first cycle after rst_n is released.
REQ-032 Reset mid-LOAD, mid-SETTLE or mid-SEND SHALL discard all partial data immediately, with no remaining transfer.

Structure
REQ-033 A shared package (vektor_pkg) SHALL hold the state encoding, BYTE_W=8, VEC_LEN=4 and the default SETTLE_CYCLES.
REQ-034 kryssprodukt SHALL NOT be instantiated inside this block; the two blocks SHALL be connected at the next level up.
REQ-035 vektor_sekvenser SHALL contain no sub-modules; it is a single FSM with counters.

Verification
REQ-036 Basic sequence: reset, then stream 0,2,4,6,1,3,5,7 with in_valid held high.
- Response: a_vec=32'h06040200 and b_vec=32'h07050301.
- Response: in_ready drops after the 8th byte.
- Response: out_valid rises 3 cycles later.
REQ-037 Result order: stub c_vec=32'h44332211 with out_ready held high -> out_data is 11,22,33,44 on consecutive cycles, then in_ready=1.
REQ-038 Backpressure: hold out_ready low for 5 cycles at idx 1 -> out_data stays 22 and out_valid stays 1; no byte is lost or repeated.
REQ-039 Input gaps and extra bytes, both cases below.
- Stimulus: bubbles on in_valid between bytes. Response: vectors are identical to REQ-036.
- Stimulus: in_valid high during SETTLE/SEND. Response: no write to a_vec or b_vec.
REQ-040 Mid-operation reset: assert rst_n low after byte 5, then after reset feed a full new set -> all outputs are 0 during reset, and the new set loads from a1.
REQ-041 Capture timing: c_vec changes after capture, during SEND -> out_data still reflects the captured value.
